// File: rtl/axi_aw_w_arbiter.sv
// AXI AW/W arbiter: round-robin AW arbitration with a registered AW stage, plus an
// order FIFO that routes W bursts in AW-issue order. Define AXI_ARB_FIXED_PRIO_EN for fixed priority.
module axi_aw_w_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] s_awaddr,
  input  logic [NUM_MASTERS*8-1:0]          s_awlen,
  input  logic [NUM_MASTERS*3-1:0]          s_awburst,
  input  logic [NUM_MASTERS*3-1:0]          s_awprot,
  input  logic [NUM_MASTERS-1:0]            s_awvalid,
  output logic [NUM_MASTERS-1:0]            s_awready,
  output logic [ADDR_WIDTH-1:0]             m_awaddr,
  output logic [7:0]                        m_awlen,
  output logic [2:0]                        m_awburst,
  output logic [2:0]                        m_awprot,
  output logic                              m_awvalid,
  input  logic                              m_awready,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] s_wdata,
  input  logic [NUM_MASTERS-1:0]            s_wlast,
  input  logic [NUM_MASTERS-1:0]            s_wvalid,
  output logic [NUM_MASTERS-1:0]            s_wready,
  output logic [DATA_WIDTH-1:0]             m_wdata,
  output logic                              m_wlast,
  output logic                              m_wvalid,
  input  logic                              m_wready
);

  localparam int IDX_W = $clog2(NUM_MASTERS);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } aw_state_t;

  aw_state_t        state;
  aw_state_t        state_nxt;
  logic [IDX_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             fifo_full;
  logic             fifo_empty;
  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] head;
  logic             aw_accept;
  logic             w_pop;

  assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count == {CNT_W{1'b0}});
  assign head       = fifo_mem[rd_ptr];

`ifdef AXI_ARB_FIXED_PRIO_EN
  // Winner selection: lowest asserted index
  always_comb begin
    winner = {IDX_W{1'b0}};
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      winner = s_awvalid[i] ? IDX_W'(i) : winner;
    end
  end
`else
  localparam int SUM_W = IDX_W + 1;

  logic [IDX_W-1:0] rr_ptr;
  logic [SUM_W-1:0] cand;
  logic             found;

  // Winner selection: first asserted index at or above rr_ptr, wrapping
  always_comb begin
    winner = {IDX_W{1'b0}};
    found  = 1'b0;
    cand   = {SUM_W{1'b0}};
    for (int i = 0; i < NUM_MASTERS; i++) begin
      cand   = {1'b0, rr_ptr} + SUM_W'(i);
      cand   = (cand >= SUM_W'(NUM_MASTERS)) ? (cand - SUM_W'(NUM_MASTERS)) : cand;
      winner = (!found && s_awvalid[cand[IDX_W-1:0]]) ? cand[IDX_W-1:0] : winner;
      found  = found | s_awvalid[cand[IDX_W-1:0]];
    end
  end

  // Round-robin pointer: start just past the last winner
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rr_ptr <= {IDX_W{1'b0}};
    end else if (aw_accept) begin
      rr_ptr <= (winner == IDX_W'(NUM_MASTERS - 1)) ? {IDX_W{1'b0}} : (winner + IDX_W'(1));
    end
  end
`endif

  // Reset gates the accept so no ready leaks out while aresetn is low
  assign aw_accept = aresetn && ((state == IDLE) || ((state == FULL) && m_awready)) &&
                     (|s_awvalid) && !fifo_full;
  assign w_pop     = m_wvalid && m_wready && m_wlast;
  assign m_awvalid = (state == FULL);

  // AW handshake back to the winning master
  always_comb begin
    s_awready         = {NUM_MASTERS{1'b0}};
    s_awready[winner] = aw_accept;
  end

  // AW FSM next-state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = aw_accept ? FULL : IDLE;
      FULL:    state_nxt = (aw_accept || !m_awready) ? FULL : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // AW FSM state register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // AW output payload register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_awaddr  <= {ADDR_WIDTH{1'b0}};
      m_awlen   <= 8'd0;
      m_awburst <= 3'd0;
      m_awprot  <= 3'd0;
    end else if (aw_accept) begin
      m_awaddr  <= s_awaddr[winner*ADDR_WIDTH +: ADDR_WIDTH];
      m_awlen   <= s_awlen[winner*8 +: 8];
      m_awburst <= s_awburst[winner*3 +: 3];
      m_awprot  <= s_awprot[winner*3 +: 3];
    end
  end

  // Order FIFO storage; contents are only read when count is non-zero
  always_ff @(posedge aclk) begin
    if (aw_accept) begin
      fifo_mem[wr_ptr] <= winner;
    end
  end

  // Order FIFO pointers and occupancy
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= {PTR_W{1'b0}};
      rd_ptr <= {PTR_W{1'b0}};
      count  <= {CNT_W{1'b0}};
    end else begin
      if (aw_accept) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(aw_accept) - CNT_W'(w_pop);
    end
  end

  // W routing from the FIFO head; non-head masters stall
  always_comb begin
    s_wready       = {NUM_MASTERS{1'b0}};
    m_wvalid       = !fifo_empty && s_wvalid[head];
    m_wdata        = s_wdata[head*DATA_WIDTH +: DATA_WIDTH];
    m_wlast        = s_wlast[head];
    s_wready[head] = !fifo_empty && m_wready;
  end

endmodule

// File: tb/tb_axi_aw_w_arbiter.sv
// Bench for axi_aw_w_arbiter: directed scenarios plus randomized traffic against a queue-based model.
module tb_axi_aw_w_arbiter;

  logic         aclk = 1'b0;
  logic         aresetn = 1'b0;
  logic [127:0] s_awaddr;
  logic [31:0]  s_awlen;
  logic [11:0]  s_awburst;
  logic [11:0]  s_awprot;
  logic [3:0]   s_awvalid;
  logic [3:0]   s_awready;
  logic [31:0]  m_awaddr;
  logic [7:0]   m_awlen;
  logic [2:0]   m_awburst;
  logic [2:0]   m_awprot;
  logic         m_awvalid;
  logic         m_awready;
  logic [127:0] s_wdata;
  logic [3:0]   s_wlast;
  logic [3:0]   s_wvalid;
  logic [3:0]   s_wready;
  logic [31:0]  m_wdata;
  logic         m_wlast;
  logic         m_wvalid;
  logic         m_wready;

  int checks = 0;
  int failures = 0;

  // Reference model state: grant order queue, pointer, registered AW slot
  int          mq[$];
  int          m_rr;
  bit          m_full;
  logic [31:0] m_addr;
  logic [7:0]  m_len;
  logic [2:0]  m_burst;
  logic [2:0]  m_prot;
  bit          e_acc;
  int          e_win;
  logic [3:0]  e_awready;
  logic [3:0]  e_wready;
  logic        e_wvalid;
  logic        e_wlast;
  logic [31:0] e_wdata;

  axi_aw_w_arbiter #(.NUM_MASTERS(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .FIFO_DEPTH(4)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awburst(s_awburst), .s_awprot(s_awprot),
    .s_awvalid(s_awvalid), .s_awready(s_awready),
    .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awburst(m_awburst), .m_awprot(m_awprot),
    .m_awvalid(m_awvalid), .m_awready(m_awready),
    .s_wdata(s_wdata), .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .m_wdata(m_wdata), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready)
  );

  always #5 aclk = ~aclk;

  task automatic clear_inputs();
    s_awaddr = '0; s_awlen = '0; s_awburst = '0; s_awprot = '0; s_awvalid = '0;
    m_awready = 1'b0; s_wdata = '0; s_wlast = '0; s_wvalid = '0; m_wready = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge aclk);
    #1;
  endtask

  task automatic apply_reset();
    aresetn = 1'b0;
    clear_inputs();
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    next_cycle();
  endtask

  task automatic model_reset();
    mq.delete();
    m_rr = 0; m_full = 1'b0;
    m_addr = '0; m_len = '0; m_burst = '0; m_prot = '0;
  endtask

  // Expected combinational outputs for the current inputs and model state
  task automatic model_eval();
    int h;
    e_acc = 1'b0; e_win = 0; e_awready = '0; e_wready = '0;
    e_wvalid = 1'b0; e_wlast = 1'b0; e_wdata = '0;
    if ((!m_full || m_awready) && s_awvalid != 4'b0000 && mq.size() < 4) begin
`ifdef AXI_ARB_FIXED_PRIO_EN
      for (int k = 3; k >= 0; k--) if (s_awvalid[k]) e_win = k;
`else
      for (int k = 3; k >= 0; k--) if (s_awvalid[(m_rr + k) % 4]) e_win = (m_rr + k) % 4;
`endif
      e_acc = 1'b1;
      e_awready[e_win] = 1'b1;
    end
    if (mq.size() > 0) begin
      h = mq[0];
      e_wvalid = s_wvalid[h];
      e_wlast  = s_wlast[h];
      e_wdata  = s_wdata[h*32 +: 32];
      e_wready[h] = m_wready;
    end
  endtask

  // Model state update for the clock edge just taken
  task automatic model_commit();
    if (mq.size() > 0 && e_wvalid && m_wready && e_wlast) void'(mq.pop_front());
    if (e_acc) begin
      mq.push_back(e_win);
      m_rr = (e_win + 1) % 4;
      m_full = 1'b1;
      m_addr = s_awaddr[e_win*32 +: 32];
      m_len = s_awlen[e_win*8 +: 8];
      m_burst = s_awburst[e_win*3 +: 3];
      m_prot = s_awprot[e_win*3 +: 3];
    end else if (m_full && m_awready) begin
      m_full = 1'b0;
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    clear_inputs();
    s_awvalid = 4'b1111; s_wvalid = 4'b1111; m_awready = 1'b1; m_wready = 1'b1;
    @(posedge aclk);
    #1;
    checks++; if (m_awvalid !== 1'b0) begin failures++; $display("FAIL reset_awvalid actual=%b required=0", m_awvalid); end
    checks++; if (m_awaddr !== 32'd0 || m_awlen !== 8'd0) begin failures++; $display("FAIL reset_payload actual=%h/%h required=0/0", m_awaddr, m_awlen); end
    checks++; if (s_awready !== 4'b0000) begin failures++; $display("FAIL reset_awready actual=%b required=0000", s_awready); end
    checks++; if (s_wready !== 4'b0000 || m_wvalid !== 1'b0) begin failures++; $display("FAIL reset_w actual=%b/%b required=0000/0", s_wready, m_wvalid); end
    apply_reset();
  endtask

  task automatic test_single();
    apply_reset();
    s_awvalid = 4'b0001; s_awaddr[31:0] = 32'h100; s_awlen[7:0] = 8'd3; m_awready = 1'b1;
    #1;
    checks++; if (s_awready !== 4'b0001) begin failures++; $display("FAIL single_awready actual=%b required=0001", s_awready); end
    next_cycle();
    s_awvalid = 4'b0000;
    #1;
    checks++; if (m_awvalid !== 1'b1 || m_awaddr !== 32'h100 || m_awlen !== 8'd3) begin
      failures++; $display("FAIL single_aw actual=%b/%h/%h required=1/00000100/03", m_awvalid, m_awaddr, m_awlen); end
    m_wready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      next_cycle();
      s_wvalid = 4'b0001; s_wdata[31:0] = 32'hD000 + 32'(j); s_wlast = (j == 3) ? 4'b0001 : 4'b0000;
      #1;
      checks++; if (m_wvalid !== 1'b1 || m_wdata !== 32'hD000 + 32'(j) || s_wready !== 4'b0001 || m_wlast !== (j == 3)) begin
        failures++; $display("FAIL single_wbeat%0d actual=%b/%h/%b/%b", j, m_wvalid, m_wdata, s_wready, m_wlast); end
    end
    next_cycle();
    #1;
    checks++; if (m_wvalid !== 1'b0 || s_wready !== 4'b0000 || m_awvalid !== 1'b0) begin
      failures++; $display("FAIL single_empty actual=%b/%b/%b required=0/0000/0", m_wvalid, s_wready, m_awvalid); end
  endtask

  task automatic test_rr_fill();
    logic [3:0] exp;
    apply_reset();
    for (int i = 0; i < 4; i++) s_awaddr[i*32 +: 32] = 32'h1000 * 32'(i + 1);
    s_awvalid = 4'b1111; m_awready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp = 4'(1 << k);
      #1;
      checks++; if (s_awready !== exp) begin failures++; $display("FAIL rr_grant%0d actual=%b required=%b", k, s_awready, exp); end
      next_cycle();
    end
    #1;
    checks++; if (s_awready !== 4'b0000 || m_awvalid !== 1'b1 || m_awaddr !== 32'h4000) begin
      failures++; $display("FAIL rr_full actual=%b/%b/%h required=0000/1/00004000", s_awready, m_awvalid, m_awaddr); end
    next_cycle();
    s_wvalid = 4'b0001; s_wlast = 4'b0001; m_wready = 1'b1;
    #1;
    checks++; if (s_awready !== 4'b0000 || s_wready !== 4'b0001 || m_awvalid !== 1'b0) begin
      failures++; $display("FAIL rr_pop_cycle actual=%b/%b/%b required=0000/0001/0", s_awready, s_wready, m_awvalid); end
    next_cycle();
    s_wvalid = 4'b0000; m_wready = 1'b0;
    #1;
    checks++; if (s_awready !== 4'b0001) begin failures++; $display("FAIL rr_after_pop actual=%b required=0001", s_awready); end
  endtask

  task automatic test_backpressure();
    apply_reset();
    s_awvalid = 4'b0001; s_awaddr[31:0] = 32'hA0; s_awlen[7:0] = 8'd7;
    #1;
    checks++; if (s_awready !== 4'b0001) begin failures++; $display("FAIL bp_first actual=%b required=0001", s_awready); end
    next_cycle();
    s_awvalid = 4'b0010; s_awaddr[63:32] = 32'hB0; s_awaddr[31:0] = 32'hDEAD;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (m_awvalid !== 1'b1 || m_awaddr !== 32'hA0 || m_awlen !== 8'd7 || s_awready !== 4'b0000) begin
        failures++; $display("FAIL bp_hold%0d actual=%b/%h/%h/%b required=1/000000a0/07/0000", c, m_awvalid, m_awaddr, m_awlen, s_awready); end
      next_cycle();
    end
    m_awready = 1'b1;
    #1;
    checks++; if (s_awready !== 4'b0010) begin failures++; $display("FAIL bp_release actual=%b required=0010", s_awready); end
    next_cycle();
    s_awvalid = 4'b0000;
    #1;
    checks++; if (m_awvalid !== 1'b1 || m_awaddr !== 32'hB0) begin failures++; $display("FAIL bp_next actual=%b/%h required=1/000000b0", m_awvalid, m_awaddr); end
  endtask

  task automatic test_w_order();
    apply_reset();
    m_awready = 1'b1; s_awvalid = 4'b0100;
    #1;
    checks++; if (s_awready !== 4'b0100) begin failures++; $display("FAIL order_aw2 actual=%b required=0100", s_awready); end
    next_cycle();
    s_awvalid = 4'b0010;
    #1;
    checks++; if (s_awready !== 4'b0010) begin failures++; $display("FAIL order_aw1 actual=%b required=0010", s_awready); end
    next_cycle();
    s_awvalid = 4'b0000; m_wready = 1'b1;
    s_wvalid = 4'b0010; s_wlast = 4'b0010; s_wdata[63:32] = 32'h11111111;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++; if (s_wready !== 4'b0100 || m_wvalid !== 1'b0) begin failures++; $display("FAIL order_stall%0d actual=%b/%b required=0100/0", c, s_wready, m_wvalid); end
      next_cycle();
    end
    s_wvalid = 4'b0110; s_wlast = 4'b0010; s_wdata[95:64] = 32'h22220000;
    #1;
    checks++; if (m_wvalid !== 1'b1 || m_wdata !== 32'h22220000 || m_wlast !== 1'b0 || s_wready !== 4'b0100) begin
      failures++; $display("FAIL order_m2b0 actual=%b/%h/%b/%b", m_wvalid, m_wdata, m_wlast, s_wready); end
    next_cycle();
    s_wlast = 4'b0110; s_wdata[95:64] = 32'h22220001;
    #1;
    checks++; if (m_wdata !== 32'h22220001 || m_wlast !== 1'b1) begin failures++; $display("FAIL order_m2b1 actual=%h/%b required=22220001/1", m_wdata, m_wlast); end
    next_cycle();
    s_wvalid = 4'b0010;
    #1;
    checks++; if (s_wready !== 4'b0010 || m_wdata !== 32'h11111111 || m_wlast !== 1'b1 || m_wvalid !== 1'b1) begin
      failures++; $display("FAIL order_m1 actual=%b/%h/%b/%b", s_wready, m_wdata, m_wlast, m_wvalid); end
    next_cycle();
    s_wvalid = 4'b0000;
    #1;
    checks++; if (m_wvalid !== 1'b0 || s_wready !== 4'b0000) begin failures++; $display("FAIL order_empty actual=%b/%b required=0/0000", m_wvalid, s_wready); end
  endtask

  task automatic test_push_pop();
    apply_reset();
    m_awready = 1'b1; s_awvalid = 4'b0001;
    #1;
    checks++; if (s_awready !== 4'b0001) begin failures++; $display("FAIL pp_first actual=%b required=0001", s_awready); end
    next_cycle();
    s_awvalid = 4'b0100; s_wvalid = 4'b0001; s_wlast = 4'b0001; m_wready = 1'b1;
    #1;
    checks++; if (s_awready !== 4'b0100 || s_wready !== 4'b0001) begin failures++; $display("FAIL pp_same actual=%b/%b required=0100/0001", s_awready, s_wready); end
    next_cycle();
    s_awvalid = 4'b0000; s_wvalid = 4'b1111; s_wlast = 4'b1111;
    #1;
    checks++; if (s_wready !== 4'b0100 || m_wvalid !== 1'b1) begin failures++; $display("FAIL pp_head actual=%b/%b required=0100/1", s_wready, m_wvalid); end
    next_cycle();
    #1;
    checks++; if (m_wvalid !== 1'b0 || s_wready !== 4'b0000) begin failures++; $display("FAIL pp_count actual=%b/%b required=0/0000", m_wvalid, s_wready); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    m_awready = 1'b1; s_awvalid = 4'b0001;
    next_cycle();
    s_awvalid = 4'b0010;
    next_cycle();
    s_awvalid = 4'b0000; m_awready = 1'b0;
    #1;
    checks++; if (m_awvalid !== 1'b1) begin failures++; $display("FAIL ar_pre actual=%b required=1", m_awvalid); end
    #1;
    aresetn = 1'b0; s_awvalid = 4'b1001; s_wvalid = 4'b1111; s_wlast = 4'b1111; m_wready = 1'b1;
    #1;
    checks++; if (m_awvalid !== 1'b0 || s_awready !== 4'b0000 || s_wready !== 4'b0000 || m_wvalid !== 1'b0) begin
      failures++; $display("FAIL ar_async actual=%b/%b/%b/%b required=0/0000/0000/0", m_awvalid, s_awready, s_wready, m_wvalid); end
    @(negedge aclk);
    aresetn = 1'b1; m_awready = 1'b1; s_wvalid = 4'b0000;
    #1;
    checks++; if (s_awready !== 4'b0001) begin failures++; $display("FAIL ar_rr actual=%b required=0001", s_awready); end
    next_cycle();
  endtask

`ifdef AXI_ARB_FIXED_PRIO_EN
  task automatic test_fixed_prio();
    apply_reset();
    s_awvalid = 4'b1001; m_awready = 1'b1; m_wready = 1'b1; s_wvalid = 4'b1111; s_wlast = 4'b1111;
    for (int c = 0; c < 6; c++) begin
      #1;
      checks++; if (s_awready !== 4'b0001) begin failures++; $display("FAIL fixed_m0_%0d actual=%b required=0001", c, s_awready); end
      next_cycle();
    end
    s_awvalid = 4'b1000;
    #1;
    checks++; if (s_awready !== 4'b1000) begin failures++; $display("FAIL fixed_m3 actual=%b required=1000", s_awready); end
  endtask
`endif

  task automatic test_random();
    apply_reset();
    model_reset();
    for (int n = 0; n < 1500; n++) begin
      s_awvalid = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom);
      s_awaddr  = {$urandom, $urandom, $urandom, $urandom};
      s_awlen   = $urandom;
      s_awburst = 12'($urandom);
      s_awprot  = 12'($urandom);
      m_awready = ($urandom_range(0, 3) != 0);
      s_wdata   = {$urandom, $urandom, $urandom, $urandom};
      s_wvalid  = 4'($urandom);
      s_wlast   = 4'($urandom) & 4'($urandom);
      m_wready  = ($urandom_range(0, 3) != 0);
      #1;
      model_eval();
      checks++; if (s_awready !== e_awready) begin failures++; $display("FAIL rnd_awready n=%0d actual=%b required=%b", n, s_awready, e_awready); end
      checks++; if (m_awvalid !== m_full) begin failures++; $display("FAIL rnd_awvalid n=%0d actual=%b required=%b", n, m_awvalid, m_full); end
      if (m_full) begin
        checks++; if ({m_awaddr, m_awlen, m_awburst, m_awprot} !== {m_addr, m_len, m_burst, m_prot}) begin
          failures++; $display("FAIL rnd_payload n=%0d actual=%h/%h/%h/%h required=%h/%h/%h/%h", n, m_awaddr, m_awlen, m_awburst, m_awprot, m_addr, m_len, m_burst, m_prot); end
      end
      checks++; if (s_wready !== e_wready || m_wvalid !== e_wvalid) begin
        failures++; $display("FAIL rnd_w n=%0d actual=%b/%b required=%b/%b", n, s_wready, m_wvalid, e_wready, e_wvalid); end
      if (e_wvalid) begin
        checks++; if (m_wdata !== e_wdata || m_wlast !== e_wlast) begin
          failures++; $display("FAIL rnd_wdata n=%0d actual=%h/%b required=%h/%b", n, m_wdata, m_wlast, e_wdata, e_wlast); end
      end
      @(posedge aclk);
      model_commit();
      #1;
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single();
`ifndef AXI_ARB_FIXED_PRIO_EN
    test_rr_fill();
`endif
    test_backpressure();
    test_w_order();
    test_push_pop();
    test_async_reset();
`ifdef AXI_ARB_FIXED_PRIO_EN
    test_fixed_prio();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
